// File: rtl/sreg_pkg.sv
// Shared constants and FSM state type for the pixel shift-register readout controller.
package sreg_pkg;
   localparam int SREG_W    = 42;
   localparam int SREG_HALF = 21;
   localparam int CNT_W     = $clog2(SREG_HALF);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DRAIN
   } sreg_state_t;
endpackage

// File: rtl/sreg_deser.sv
// Two-lane capture shift registers; word_nxt is the assembled word including the sample
// being taken this cycle, so the final DRAIN sample is visible before it is registered.
module sreg_deser
   import sreg_pkg::*;
#(
   parameter int HALF_W = SREG_HALF
) (
   input  logic                  sclk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  smp_en,
   input  logic [1:0]            sreg_in,
   output logic [2*HALF_W-1:0]   word_nxt
);
   logic [HALF_W-1:0] lane0, lane1;
   logic [HALF_W-1:0] lane0_nxt, lane1_nxt;

   always_comb begin
      lane0_nxt = lane0;
      lane1_nxt = lane1;
      if (smp_en) begin
         lane0_nxt = {lane0[HALF_W-2:0], sreg_in[0]};
         lane1_nxt = {lane1[HALF_W-2:0], sreg_in[1]};
      end
   end

   assign word_nxt = {lane0_nxt, lane1_nxt};

   always_ff @(posedge sclk) begin
      if (!rst_n || clr) begin
         lane0 <= '0;
         lane1 <= '0;
      end else begin
         lane0 <= lane0_nxt;
         lane1 <= lane1_nxt;
      end
   end
endmodule

// File: rtl/sreg_readout_ctrl.sv
// Drives shift/serial_out for the pixel register, writes a new config into its lower half
// and rebuilds the 42-bit readout; data_valid lands LOAD_CYCLES+HALF_W+2 cycles after start.
module sreg_readout_ctrl
   import sreg_pkg::*;
#(
   parameter int WORD_W      = SREG_W,
   parameter int HALF_W      = SREG_HALF,
   parameter int LOAD_CYCLES = 1
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [HALF_W-1:0] cfg_in,
   output logic              busy,
   output logic              shift,
   output logic              serial_out,
   input  logic [1:0]        sreg_in,
   output logic [WORD_W-1:0] data_out,
   output logic              data_valid
);
   localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(HALF_W - 1);

   sreg_state_t       state;
   logic [CNT_W-1:0]  cnt;
   logic [HALF_W-1:0] cfg_q;
   logic              cap_clr;
   logic              cap_en;
   logic [WORD_W-1:0] word_nxt;

   // The pair launched by shift cycle k arrives one cycle later, so the first SHIFT cycle
   // has nothing to capture and DRAIN catches the last pair.
   assign cap_clr = (state == IDLE) && start;
   assign cap_en  = ((state == SHIFT) && (cnt != '0)) || (state == DRAIN);

   sreg_deser #(
      .HALF_W (HALF_W)
   ) u_deser (
      .sclk     (sclk),
      .rst_n    (rst_n),
      .clr      (cap_clr),
      .smp_en   (cap_en),
      .sreg_in  (sreg_in),
      .word_nxt (word_nxt)
   );

   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         cfg_q      <= '0;
         busy       <= 1'b0;
         shift      <= 1'b0;
         serial_out <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cfg_q <= cfg_in;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (cnt == LOAD_LAST) begin
                  cnt        <= '0;
                  shift      <= 1'b1;
                  serial_out <= cfg_q[HALF_W-1];
                  cfg_q      <= {cfg_q[HALF_W-2:0], 1'b0};
                  state      <= SHIFT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SHIFT: begin
               if (cnt == SHIFT_LAST) begin
                  cnt        <= '0;
                  shift      <= 1'b0;
                  serial_out <= 1'b0;
                  state      <= DRAIN;
               end else begin
                  cnt        <= cnt + CNT_W'(1);
                  serial_out <= cfg_q[HALF_W-1];
                  cfg_q      <= {cfg_q[HALF_W-2:0], 1'b0};
               end
            end
            DRAIN: begin
               busy       <= 1'b0;
               data_valid <= 1'b1;
               data_out   <= word_nxt;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sreg_readout_ctrl.sv
// Bench for sreg_readout_ctrl with a behavioural pixel shift register attached.
module tb_sreg_readout_ctrl;
   logic        sclk;
   logic        rst_n;
   logic        start;
   logic [20:0] cfg_in;
   logic        busy;
   logic        shift;
   logic        serial_out;
   logic [1:0]  sreg_in;
   logic [41:0] data_out;
   logic        data_valid;

   int n_cmp = 0;
   int n_bad = 0;

   sreg_readout_ctrl dut (
      .sclk       (sclk),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_in     (cfg_in),
      .busy       (busy),
      .shift      (shift),
      .serial_out (serial_out),
      .sreg_in    (sreg_in),
      .data_out   (data_out),
      .data_valid (data_valid)
   );

   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   // Pixel register: loads its shift chain while shift is low, shifts both lanes while
   // high (upper lane fed with 0, lower lane with serial_in), commits on shift falling.
   logic [41:0] pix     = '0;
   logic [41:0] sr      = '0;
   logic [1:0]  sro     = '0;
   logic        shift_d = 1'b0;
   logic        pre_en  = 1'b0;
   logic [41:0] pre_val = '0;

   assign sreg_in = sro;

   always @(posedge sclk) begin
      shift_d <= shift;
      if (pre_en)
         pix <= pre_val;
      else if (!shift && shift_d)
         pix <= sr;
      if (shift) begin
         sro <= {sr[20], sr[41]};
         sr  <= {sr[40:21], 1'b0, sr[19:0], serial_out};
      end else begin
         sr <= pix;
      end
   end

   // Reference: a pass returns the stored word and leaves {zeros, cfg} behind.
   logic [41:0] mdl_pix = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [41:0] v);
      pre_val = v;
      pre_en  = 1'b1;
      @(negedge sclk);
      pre_en  = 1'b0;
      mdl_pix = v;
   endtask

   task automatic run_pass(input logic [20:0] cfg, input bit pre_started, input int mid1,
                           input int mid2, input bit chain, input logic [20:0] next_cfg,
                           input string tag);
      logic [41:0] exp;
      logic [20:0] ser;
      int          nshift, nbusy, dv_at, nser_low;
      bit          done;
      exp = mdl_pix;
      ser = '0;
      nshift = 0; nbusy = 0; dv_at = -1; nser_low = 0; done = 1'b0;
      if (!pre_started) begin
         start  = 1'b1;
         cfg_in = cfg;
      end
      for (int i = 1; i <= 40 && !done; i++) begin
         @(negedge sclk);
         start = (i == mid1) || (i == mid2);
         if (start) cfg_in = 21'($urandom);
         if (shift) begin
            nshift++;
            ser = {ser[19:0], serial_out};
         end else if (serial_out) begin
            nser_low++;
         end
         if (busy) nbusy++;
         if (data_valid) begin
            dv_at = i;
            done  = 1'b1;
            check({tag, ".data_out"}, 64'(data_out), 64'(exp));
            check({tag, ".busy_at_valid"}, 64'(busy), 64'(1'b0));
            if (chain) begin
               start  = 1'b1;
               cfg_in = next_cfg;
            end
         end
      end
      mdl_pix = {21'b0, cfg};
      check({tag, ".valid_seen"}, 64'(done), 64'(1'b1));
      check({tag, ".valid_cycle"}, 64'(dv_at), 64'(24));
      check({tag, ".shift_cycles"}, 64'(nshift), 64'(21));
      check({tag, ".busy_cycles"}, 64'(nbusy), 64'(23));
      check({tag, ".serial_bits"}, 64'(ser), 64'(cfg));
      check({tag, ".serial_idle_low"}, 64'(nser_low), 64'(0));
      check({tag, ".pixel_after"}, 64'(pix), 64'(mdl_pix));
   endtask

   initial begin
      logic [41:0] hold;
      logic [41:0] pv;
      logic [20:0] cv;
      int          ndv;
      rst_n  = 1'b0;
      start  = 1'b1;
      cfg_in = 21'h15555;

      // Reset held with start asserted
      for (int i = 0; i < 3; i++) begin
         @(negedge sclk);
         check("rst.shift", 64'(shift), 64'(1'b0));
         check("rst.busy", 64'(busy), 64'(1'b0));
         check("rst.valid", 64'(data_valid), 64'(1'b0));
         check("rst.data_out", 64'(data_out), 64'(42'h0));
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge sclk);

      // Readout of a preloaded alternating pattern
      preload(42'h2AA_AAAA_AAAA);
      run_pass(21'h0, 1'b0, -1, -1, 1'b0, 21'h0, "alt");
      hold = data_out;
      for (int i = 0; i < 5; i++) begin
         @(negedge sclk);
         check("hold.valid", 64'(data_valid), 64'(1'b0));
      end
      check("hold.data_out", 64'(data_out), 64'(hold));

      // Config round trip
      run_pass(21'h1F0F0, 1'b0, -1, -1, 1'b0, 21'h0, "cfg1");
      @(negedge sclk);
      run_pass(21'h0, 1'b0, -1, -1, 1'b0, 21'h0, "cfg2");
      @(negedge sclk);

      // Single MSB set in config
      run_pass(21'h100000, 1'b0, -1, -1, 1'b0, 21'h0, "msb");
      @(negedge sclk);

      // Mid-pass starts ignored, start in the valid cycle chains a second pass
      preload({10'($urandom), $urandom});
      cv = 21'($urandom);
      run_pass(21'h0ABCD, 1'b0, 5, 15, 1'b1, cv, "chain1");
      run_pass(cv, 1'b1, -1, -1, 1'b0, 21'h0, "chain2");
      ndv = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge sclk);
         if (data_valid) ndv++;
      end
      check("chain.extra_valid", 64'(ndv), 64'(0));

      // Reset in SHIFT cycle 10
      start  = 1'b1;
      cfg_in = 21'h12345;
      for (int i = 1; i <= 11; i++) begin
         @(negedge sclk);
         start = 1'b0;
      end
      check("mid.shift_before", 64'(shift), 64'(1'b1));
      rst_n = 1'b0;
      @(negedge sclk);
      rst_n = 1'b1;
      check("mid.shift", 64'(shift), 64'(1'b0));
      check("mid.busy", 64'(busy), 64'(1'b0));
      check("mid.data_out", 64'(data_out), 64'(42'h0));
      ndv = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge sclk);
         if (data_valid) ndv++;
      end
      check("mid.no_valid", 64'(ndv), 64'(0));
      preload(42'h155_5555_5555);
      run_pass(21'h0F00F, 1'b0, -1, -1, 1'b0, 21'h0, "post_rst");

      // Randomised passes with random gaps
      for (int r = 0; r < 6; r++) begin
         pv = {10'($urandom), $urandom};
         preload(pv);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(negedge sclk);
         run_pass(21'($urandom), 1'b0, -1, -1, 1'b0, 21'h0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sreg_readout_ctrl.md
Name: sreg_readout_ctrl

Overview:
Host-side controller for the pixel configuration/readout shift register chain. It drives the chain's `shift` strobe and `serial_in` bit. It captures the two serial lanes the pixel register returns (upper half on lane 0, lower half on lane 1) and rebuilds the 42-bit pixel word. In the same pass it shifts a new 21-bit configuration word into the lower half. Controller and pixel register share `sclk`, and the pixel register acts on the rising edge.

Parameters:
WORD_W, 42, width of the pixel shift register
HALF_W, 21, length of each lane; must equal WORD_W/2
LOAD_CYCLES, 1, cycles `shift` is held low before shifting so the pixel register parallel-loads

Ports:
sclk        input   1        system clock; everything acts on the rising edge
rst_n       input   1        synchronous reset, active-low
start       input   1        request one readout/config pass; accepted only in IDLE
cfg_in      input   HALF_W   config word, sampled when start is accepted
busy        output  1        pass in progress
shift       output  1        registered; to the pixel register shift input
serial_out  output  1        registered; to the pixel register serial_in
sreg_in     input   2        from pixel register sreg_out; [0] = upper lane, [1] = lower lane
data_out    output  WORD_W   reconstructed pixel word; held until the next pass completes
data_valid  output  1        1-cycle pulse when data_out updates

Behaviour:
Interface:
- One clock, `sclk`.
- Reset `rst_n` is synchronous and active-low.

Reset values: shift=0, serial_out=0, busy=0, data_valid=0, data_out=0, state=IDLE, counters=0.

FSM states: IDLE -> LOAD -> SHIFT -> DRAIN -> IDLE.
- IDLE
  - shift=0, busy=0.
  - On start=1: latch cfg_in into cfg_q, clear capture registers, go to LOAD.
- LOAD
  - shift=0, busy=1, held for LOAD_CYCLES cycles.
  - Then go to SHIFT with cnt=0.
- SHIFT
  - shift=1, busy=1, held for exactly HALF_W cycles (cnt 0..HALF_W-1).
  - serial_out = cfg_q[HALF_W-1-cnt], so cfg is sent MSB first.
  - Let k = cnt+1 (shift cycle 1..HALF_W). The pixel register updates sreg_out at the end of shift cycle k; the controller samples that pair at the end of cycle k+1.
  - Sampling therefore happens in SHIFT while cnt≥1, plus the DRAIN cycle.
- DRAIN
  - shift=0, serial_out=0, busy=1, one cycle; samples the final pair.
  - The falling edge of shift commits the shifted word back into the pixel register.
  - Next cycle: data_valid=1, data_out updated, busy=0, state=IDLE.

Capture mapping for sample j (j=0..HALF_W-1):
- data_out bit [WORD_W-1-j] takes sreg_in[0].
- data_out bit [HALF_W-1-j] takes sreg_in[1].
- Implement each lane as a left-shift register; assign data_out = {lane0, lane1} on completion.

Latency:
- Start is sampled at edge E0.
- data_valid is high in cycle LOAD_CYCLES + HALF_W + 2 after E0; that is cycle 24 with default parameters.
- shift is high for exactly HALF_W consecutive cycles per pass.

Boundary conditions:
- start while busy: ignored, not queued.
- start in the data_valid cycle: accepted, since the state is already IDLE. Back-to-back passes are therefore allowed.
- rst_n low mid-pass: the next cycle shows reset values. No data_valid is produced, and data_out is cleared. The pixel register contents are then undefined to the system and are not the controller's concern.
- Upper lane: receives no new data. After a pass, the pixel register upper half holds zeros and its lower half holds cfg_q.

Decomposition:
- Package `sreg_pkg` holds:
  - SREG_W=42 and SREG_HALF=21 constants
  - the state enum type (IDLE, LOAD, SHIFT, DRAIN)
  - the counter width, clog2(SREG_HALF)
- Sub-module `sreg_deser`: the two-lane capture shift registers, with sample enable and clear. It outputs the assembled WORD_W word.

Test Plan:
1. rst_n=0 for 3 cycles, start=1 -> shift=0, busy=0, data_valid=0, data_out=0 throughout.
2. Model preloaded with pixel=42'h2AA_AAAA_AAAA, cfg_in=0, start pulse -> shift high exactly 21 cycles; data_valid in cycle 24 with data_out=42'h2AA_AAAA_AAAA.
3. cfg_in=21'h1F0F0 pass, then second pass with cfg_in=0 -> second data_out=42'h000_0001_F0F0; model pixel word afterwards = 0.
4. cfg_in=21'h100000 -> serial_out=1 only in the first SHIFT cycle and 0 in the other 20 SHIFT cycles.
5. start re-asserted at cycles 5 and 15 of a pass, then in the data_valid cycle -> the mid-pass starts are ignored; a second pass begins the cycle after data_valid; exactly two data_valid pulses.
6. rst_n=0 in SHIFT cycle 10 -> shift=0 and busy=0 the next cycle, no data_valid, data_out=0; a fresh start then completes normally with the pixel reloaded from the model.
